// File: rtl/mont_modmul_hs.sv
// rtl/mont_modmul_hs.sv - radix-2 Montgomery a*b mod p with per-op modulus and valid/ready handshakes
// Optional MODMUL_ZERO_SKIP_EN: zero operands finish in one cycle.
module mont_modmul_hs #(
    parameter int WIDTH = 256,
    localparam int CNTW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] r2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] product,
    output logic             err,
    output logic             busy
);

    typedef enum logic [2:0] {IDLE, PASS1, FIX1, PASS2, FIX2, DONE} state_t;

    state_t           state;
    logic [WIDTH+1:0] u;
    logic [WIDTH-1:0] xr;
    logic [WIDTH-1:0] yr;
    logic [WIDTH-1:0] pr;
    logic [WIDTH-1:0] r2r;
    logic [CNTW-1:0]  cnt;

    logic [WIDTH+1:0] s1;
    logic [WIDTH+1:0] s2;
    logic [WIDTH+1:0] u_next;
    logic [WIDTH-1:0] t_fix;
    logic             skip;
    logic             last_iter;

`ifdef MODMUL_ZERO_SKIP_EN
    assign skip = (a == '0) || (b == '0);
`else
    assign skip = 1'b0;
`endif

    // One Montgomery step: add x[i]*y, make u even by adding p, then halve.
    always_comb begin
        s1     = u + (xr[0] ? {2'b00, yr} : '0);
        s2     = s1 + (s1[0] ? {2'b00, pr} : '0);
        u_next = s2 >> 1;
        t_fix  = (u >= {2'b00, pr}) ? WIDTH'(u - {2'b00, pr}) : WIDTH'(u);
    end

    assign last_iter = (cnt == CNTW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            product   <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
            u         <= '0;
            xr        <= '0;
            yr        <= '0;
            pr        <= '0;
            r2r       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        xr       <= a;
                        yr       <= b;
                        pr       <= p;
                        r2r      <= r2;
                        u        <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        // Even modulus or skipped zero: u stays 0, so FIX2 yields product 0.
                        state    <= (!p[0] || skip) ? FIX2 : PASS1;
                    end
                end
                PASS1, PASS2: begin
                    u   <= u_next;
                    xr  <= xr >> 1;
                    cnt <= cnt + CNTW'(1);
                    if (last_iter) state <= (state == PASS1) ? FIX1 : FIX2;
                end
                FIX1: begin
                    xr    <= t_fix;
                    yr    <= r2r;
                    u     <= '0;
                    cnt   <= '0;
                    state <= PASS2;
                end
                FIX2: begin
                    product   <= pr[0] ? t_fix : '0;
                    err       <= ~pr[0];
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        err       <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mont_modmul_hs.sv
// tb/tb_mont_modmul_hs.sv - directed-vector bench for mont_modmul_hs at WIDTH=8, p=251, r2=25
module tb_mont_modmul_hs;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] p;
    logic [W-1:0] r2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] product;
    logic         err;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef MODMUL_ZERO_SKIP_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 18;
`endif

    mont_modmul_hs #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .p         (p),
        .r2        (r2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic [W-1:0] ip, input logic [W-1:0] ep, input logic ee,
                          input int elat, input int hold);
        int  lat;
        logic stable;
        a        = ia;
        b        = ib;
        p        = ip;
        r2       = 8'd25;
        in_valid = 1'b1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(elat));
        check({tag, "_product"}, 32'(product), 32'(ep));
        check({tag, "_err"}, 32'(err), 32'(ee));
        stable = 1'b1;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || product !== ep || err !== ee || in_ready !== 1'b0)
                stable = 1'b0;
        end
        if (hold > 0) check({tag, "_hold_stable"}, 32'(stable), 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_post_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_post_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        p         = '0;
        r2        = '0;
        #12;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_product", 32'(product), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_op("mul_3_5", 8'd3, 8'd5, 8'd251, 8'd15, 1'b0, 18, 0);
        run_op("mul_250_250", 8'd250, 8'd250, 8'd251, 8'd1, 1'b0, 18, 0);
        run_op("mul_200_100", 8'd200, 8'd100, 8'd251, 8'd171, 1'b0, 18, 0);
        run_op("mul_0_77", 8'd0, 8'd77, 8'd251, 8'd0, 1'b0, ZERO_LAT, 0);
        run_op("even_p", 8'd3, 8'd5, 8'd250, 8'd0, 1'b1, 1, 0);
        run_op("after_even", 8'd3, 8'd5, 8'd251, 8'd15, 1'b0, 18, 0);
        run_op("hold", 8'd250, 8'd250, 8'd251, 8'd1, 1'b0, 18, 10);

        // Abort an operation partway through the second pass.
        a        = 8'd11;
        b        = 8'd13;
        p        = 8'd251;
        r2       = 8'd25;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("midop_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_async_in_ready", 32'(in_ready), 32'd1);
        check("rst_async_out_valid", 32'(out_valid), 32'd0);
        check("rst_async_busy", 32'(busy), 32'd0);
        check("rst_async_product", 32'(product), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_no_stale_valid", 32'(out_valid), 32'd0);
        run_op("mul_7_9", 8'd7, 8'd9, 8'd251, 8'd63, 1'b0, 18, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
